// File: rtl/io_mmio_bridge_pkg.sv
// Shared definitions for the MMIO bridge: register word offsets
// (io_addr[4:2]), button bit positions and the bus handshake states.
package io_pkg;

    // Word offsets inside the 32-byte register window
    localparam logic [2:0] OFF_DISP      = 3'd0;  // 0x00
    localparam logic [2:0] OFF_BTN_STATE = 3'd1;  // 0x04
    localparam logic [2:0] OFF_BTN_EVENT = 3'd2;  // 0x08
    localparam logic [2:0] OFF_IRQ_EN    = 3'd3;  // 0x0C
    localparam logic [2:0] OFF_BTN_COUNT = 3'd4;  // 0x10

    // Bit positions of the buttons in every 4-bit button vector
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;

    typedef enum logic {IDLE, RESP} io_bus_state_t;

endpackage

// File: rtl/io_mmio_bridge_if.sv
// CPU data-bus side of the MMIO bridge. The CPU is the master; the
// bridge is the slave and answers each request with a one-cycle io_ready.
interface io_mmio_bridge_if;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wstrb;
    logic        io_we;
    logic        io_re;
    logic [31:0] io_rdata;
    logic        io_ready;

    modport master (
        output io_addr, io_wdata, io_wstrb, io_we, io_re,
        input  io_rdata, io_ready
    );

    modport slave (
        input  io_addr, io_wdata, io_wstrb, io_we, io_re,
        output io_rdata, io_ready
    );
endinterface

// File: rtl/io_mmio_bridge_tick_gen.sv
// Free-running divider producing a single-cycle enable pulse every DIV
// cycles. The pulse is registered off the terminal count, so the first
// pulse is seen DIV cycles after reset release. DIV must be >= 2.
module io_tick_gen #(
    parameter int DIV = 2
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count 0..DIV-1, wrap, and flag the terminal count one cycle later
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (cnt_q == LAST);
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/io_mmio_bridge.sv
// MMIO bridge between the CPU data bus and io_controller: display register,
// button level/event/IRQ-enable registers, and the LED/SSEG tick enables.
// Optional build macro IO_EVENT_COUNT_EN adds per-button rising-edge
// counters at offset 0x10; without it 0x10 reads 0 and ignores writes.
// BASE_ADDR must be 32-byte aligned; CLK_HZ/LED_HZ and CLK_HZ/SSEG_HZ >= 2.
module io_mmio_bridge
    import io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          CLK_HZ    = 100_000_000,
    parameter int          LED_HZ    = 100,
    parameter int          SSEG_HZ   = 1000
) (
    input  logic              CLK,
    input  logic              RST_N,
    io_mmio_bridge_if.slave   bus,
    input  logic              dBTNL,
    input  logic              dBTNR,
    input  logic              dBTNU,
    input  logic              dBTND,
    output logic [31:0]       R_IO,
    output logic              clk_led,
    output logic              clk_sseg,
    output logic              btn_irq
);
    localparam int LED_DIV  = CLK_HZ / LED_HZ;
    localparam int SSEG_DIV = CLK_HZ / SSEG_HZ;

    io_bus_state_t state_q, state_d;
    logic          acc, hit, wr;
    logic [2:0]    off;
    logic [31:0]   rd_mux, rdata_q, disp_q;
    logic [3:0]    btn, prev_q, evt_q, irq_en_q, evt_set, evt_clr;
    logic          unused_ok;

    assign btn = {dBTND, dBTNU, dBTNR, dBTNL};
    assign hit = (bus.io_addr[31:5] == BASE_ADDR[31:5]);
    assign off = bus.io_addr[4:2];
    // Simultaneous we/re is a write; only accepted requests take effect
    assign wr  = acc & bus.io_we & hit;

    assign unused_ok = ^bus.io_addr[1:0];

    assign evt_set = btn & ~prev_q;
    assign evt_clr = (wr && off == OFF_BTN_EVENT && bus.io_wstrb[0]) ? bus.io_wdata[3:0] : 4'b0;

`ifdef IO_EVENT_COUNT_EN
    logic [3:0][7:0] cnt_q;

    // Rising-edge counters; a clear write wins over a same-cycle edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (wr && off == OFF_BTN_COUNT) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (evt_set[i]) cnt_q[i] <= cnt_q[i] + 8'd1;
        end
    end
`endif

    // Handshake: accept in IDLE, answer for exactly one cycle in RESP
    always_comb begin
        state_d = state_q;
        acc     = 1'b0;
        case (state_q)
            IDLE: if (bus.io_we || bus.io_re) begin
                acc     = 1'b1;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read mux over pre-write register values
    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_DISP:      rd_mux = disp_q;
            OFF_BTN_STATE: rd_mux = {28'b0, btn};
            OFF_BTN_EVENT: rd_mux = {28'b0, evt_q};
            OFF_IRQ_EN:    rd_mux = {28'b0, irq_en_q};
`ifdef IO_EVENT_COUNT_EN
            OFF_BTN_COUNT: rd_mux = cnt_q;
`endif
            default:       rd_mux = '0;
        endcase
    end

    // Bus state and captured response data (writes and misses return 0)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (acc) rdata_q <= (hit && !bus.io_we) ? rd_mux : '0;
        end
    end

    // Register file: DISP with byte strobes, IRQ enable, sticky events (set wins)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            disp_q   <= '0;
            irq_en_q <= '0;
            evt_q    <= '0;
            prev_q   <= '0;
            btn_irq  <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (wr && off == OFF_DISP && bus.io_wstrb[b])
                    disp_q[b*8 +: 8] <= bus.io_wdata[b*8 +: 8];
            if (wr && off == OFF_IRQ_EN && bus.io_wstrb[0])
                irq_en_q <= bus.io_wdata[3:0];
            evt_q   <= (evt_q & ~evt_clr) | evt_set;
            prev_q  <= btn;
            btn_irq <= |(evt_q & irq_en_q);
        end
    end

    assign bus.io_ready = (state_q == RESP);
    assign bus.io_rdata = bus.io_ready ? rdata_q : '0;
    assign R_IO         = disp_q;

    io_tick_gen #(.DIV(LED_DIV))  u_led  (.CLK(CLK), .RST_N(RST_N), .tick(clk_led));
    io_tick_gen #(.DIV(SSEG_DIV)) u_sseg (.CLK(CLK), .RST_N(RST_N), .tick(clk_sseg));

endmodule

// File: tb/tb_io_mmio_bridge.sv
// Self-checking bench for io_mmio_bridge: read/write responses go through a
// scoreboard queue popped whenever io_ready is seen.
module tb_io_mmio_bridge;
    localparam logic [31:0] BASE = 32'h1100_0000;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic dBTNL = 0, dBTNR = 0, dBTNU = 0, dBTND = 0;
    logic [31:0] R_IO;
    logic clk_led, clk_sseg, btn_irq;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] sb[$];

    io_mmio_bridge_if bus_if();

    io_mmio_bridge #(
        .BASE_ADDR(BASE), .CLK_HZ(1000), .LED_HZ(100), .SSEG_HZ(250)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus_if),
        .dBTNL(dBTNL), .dBTNR(dBTNR), .dBTNU(dBTNU), .dBTND(dBTND),
        .R_IO(R_IO), .clk_led(clk_led), .clk_sseg(clk_sseg), .btn_irq(btn_irq)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    // Scoreboard: every io_ready pulse must match the oldest expectation
    always @(negedge CLK) begin
        if (RST_N && bus_if.io_ready === 1'b1) begin
            if (sb.size() == 0) chk("sb_extra_ready", 32'd1, 32'd0);
            else chk("rdata", bus_if.io_rdata, sb.pop_front());
        end
    end

    // Issue one request; called at a negedge, returns at the RESP negedge
    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp);
        bus_if.io_we    = we;
        bus_if.io_re    = ~we;
        bus_if.io_addr  = addr;
        bus_if.io_wdata = wdata;
        bus_if.io_wstrb = strb;
        sb.push_back(we ? 32'd0 : exp);
        @(posedge CLK); #1;
        bus_if.io_we = 1'b0;
        bus_if.io_re = 1'b0;
        @(negedge CLK);
        chk("ready", 32'(bus_if.io_ready), 32'd1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        @(negedge CLK);
        bus(1'b1, addr, d, s, 32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        @(negedge CLK);
        bus(1'b0, addr, 32'd0, 4'h0, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus_if.io_we = 0; bus_if.io_re = 0; bus_if.io_addr = 0;
        bus_if.io_wdata = 0; bus_if.io_wstrb = 0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_led",   32'(clk_led),  32'd0);
        chk("rst_sseg",  32'(clk_sseg), 32'd0);
        chk("rst_rio",   R_IO,          32'd0);
        chk("rst_ready", 32'(bus_if.io_ready), 32'd0);
        chk("rst_rdata", bus_if.io_rdata, 32'd0);
        chk("rst_irq",   32'(btn_irq),  32'd0);

        // Tick timing: edge k after release
        RST_N = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge CLK); #1;
            chk("clk_led",  32'(clk_led),  32'((k % 10) == 0));
            chk("clk_sseg", 32'(clk_sseg), 32'((k % 4) == 0));
        end

        // Display register with byte strobes
        wr(BASE + 0, 32'hDEAD_BEEF, 4'hF);
        wr(BASE + 0, 32'h0000_00AA, 4'b0001);
        chk("r_io", R_IO, 32'hDEAD_BEAA);
        rd(BASE + 0, 32'hDEAD_BEAA);

        // Event + interrupt on button U
        @(negedge CLK); dBTNU = 1'b1;
        @(negedge CLK); dBTNU = 1'b0;
        wr(BASE + 32'hC, 32'h4, 4'hF);
        chk("irq_lag", 32'(btn_irq), 32'd0);
        @(negedge CLK);
        chk("irq_set", 32'(btn_irq), 32'd1);
        rd(BASE + 32'h8, 32'h4);
        wr(BASE + 32'h8, 32'h4, 4'h1);
        chk("irq_hold", 32'(btn_irq), 32'd1);
        @(negedge CLK);
        chk("irq_clr", 32'(btn_irq), 32'd0);
        rd(BASE + 32'h8, 32'h0);

        // Levels and multi-bit events
        @(negedge CLK); dBTNL = 1'b1; dBTND = 1'b1;
        rd(BASE + 32'h4, 32'h9);
        @(negedge CLK); dBTNL = 1'b0; dBTND = 1'b0;
        rd(BASE + 32'h8, 32'h9);
        wr(BASE + 32'h8, 32'hF, 4'h1);
        rd(BASE + 32'h8, 32'h0);

        // Set wins over a same-cycle W1C; W1C needs byte-0 strobe
        @(negedge CLK); dBTNL = 1'b1;
        bus(1'b1, BASE + 32'h8, 32'h1, 4'h1, 32'd0);
        rd(BASE + 32'h8, 32'h1);
        wr(BASE + 32'h8, 32'h1, 4'b0010);
        rd(BASE + 32'h8, 32'h1);
        @(negedge CLK); dBTNL = 1'b0;

        // IRQ enable readback masks upper bits
        wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        rd(BASE + 32'hC, 32'hF);
        chk("irq_en_all", 32'(btn_irq), 32'd1);

        // Reserved offsets and misses
        rd(BASE + 32'h18, 32'h0);
        rd(32'h1100_0040, 32'h0);
        wr(32'h1100_0020, 32'h1234_5678, 4'hF);
        wr(BASE + 32'h1C, 32'h1234_5678, 4'hF);
        chk("miss_rio", R_IO, 32'hDEAD_BEAA);
        rd(BASE + 0, 32'hDEAD_BEAA);

        // Reset during RESP drops the response
        @(negedge CLK);
        bus_if.io_re = 1'b1; bus_if.io_addr = BASE;
        @(posedge CLK); #1;
        bus_if.io_re = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus_if.io_ready), 32'd0);
        chk("mid_rst_rio",   R_IO,                32'd0);
        chk("mid_rst_irq",   32'(btn_irq),        32'd0);
        @(negedge CLK); RST_N = 1'b1;
        rd(BASE + 0,     32'h0);
        rd(BASE + 32'h8, 32'h0);
        rd(BASE + 32'hC, 32'h0);

        // Optional edge counters
        for (int i = 0; i < 257; i++) begin
            @(negedge CLK); dBTNR = 1'b1;
            @(negedge CLK); dBTNR = 1'b0;
        end
`ifdef IO_EVENT_COUNT_EN
        rd(BASE + 32'h10, 32'h0000_0100);
`else
        rd(BASE + 32'h10, 32'h0);
`endif
        wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
        rd(BASE + 32'h10, 32'h0);
        rd(BASE + 0, 32'h0);

        repeat (2) @(negedge CLK);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
